imem_loader: RTL

Program loader for the RISC-V core's byte-addressed instruction memory. It accepts a framed byte stream over a valid/ready handshake and checks the frame length and an XOR checksum. It writes each payload byte to consecutive instruction-memory addresses from 0, in little-endian byte order, matching the fetch path's `{mem[pc+3]..mem[pc]}` assembly. It holds the core in reset while loading and reports done or error.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module : imem_loader_pkg
// Brief  : Shared types and constants for the instruction-memory loader.
// Rev    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int HDR_LEN  = 2;
    localparam int CSUM_LEN = 1;
    localparam int BYTE_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module : imem_loader
// Brief  : Framed byte-stream loader into instruction memory with length and
//          XOR checksum validation; holds the core in reset while loading.
// Rev    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 109,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    output logic              hold_cpu,
    output logic              done,
    output logic              error
);

    state_t              r_state,  w_state_nxt;
    logic [15:0]         r_len,    w_len_nxt;
    logic [15:0]         r_count,  w_count_nxt;
    logic [BYTE_W-1:0]   r_acc,    w_acc_nxt;
    logic                r_we,     w_we_nxt;
    logic [ADDR_W-1:0]   r_addr,   w_addr_nxt;
    logic [BYTE_W-1:0]   r_wdata,  w_wdata_nxt;
    logic                r_hold,   w_hold_nxt;
    logic                r_done,   w_done_nxt;
    logic                r_error,  w_error_nxt;

    logic                w_accept;
    logic [15:0]         w_len_full;
    logic [15:0]         w_count_p1;

    assign in_ready   = ((r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                         (r_state == ST_DATA)   || (r_state == ST_CSUM)) && !start;
    assign w_accept   = in_valid && in_ready;
    assign w_len_full = {in_data, r_len[7:0]};
    assign w_count_p1 = r_count + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_count <= '0;
            r_acc   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_count <= w_count_nxt;
            r_acc   <= w_acc_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_hold  <= w_hold_nxt;
            r_done  <= w_done_nxt;
            r_error <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_count_nxt = r_count;
        w_acc_nxt   = r_acc;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_hold_nxt  = r_hold;
        w_done_nxt  = r_done;
        w_error_nxt = r_error;

        // start wins over any byte on the same edge; in_ready is already low
        if (start) begin
            w_state_nxt = ST_LEN_LO;
            w_count_nxt = '0;
            w_acc_nxt   = '0;
            w_done_nxt  = 1'b0;
            w_error_nxt = 1'b0;
            w_hold_nxt  = 1'b1;
        end else if (w_accept) begin
            case (r_state)
                ST_LEN_LO: begin
                    w_len_nxt[7:0] = in_data;
                    w_state_nxt    = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    w_len_nxt = w_len_full;
                    if (w_len_full > 16'(DEPTH)) begin
                        w_state_nxt = ST_ERR;
                        w_error_nxt = 1'b1;
                    end else if (w_len_full == 16'd0) begin
                        w_state_nxt = ST_CSUM;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = r_count[ADDR_W-1:0];
                    w_wdata_nxt = in_data;
                    w_acc_nxt   = r_acc ^ in_data;
                    w_count_nxt = w_count_p1;
                    if (w_count_p1 == r_len) begin
                        w_state_nxt = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (in_data == r_acc) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        w_hold_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_ERR;
                        w_error_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign hold_cpu  = r_hold;
    assign done      = r_done;
    assign error     = r_error;

endmodule
`default_nettype wire
